// File: rtl/bf16_pkg.sv
// Shared bfloat16 format definitions for the arithmetic library.
package bf16_pkg;

  localparam int unsigned BF16_BIAS      = 127;
  localparam logic [7:0]  BF16_EXP_MAX   = 8'hFF;
  localparam logic [15:0] BF16_QNAN      = 16'h7FC0;
  localparam int unsigned BF16_QUOT_BITS = 11;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  typedef enum logic [1:0] {IDLE, DIV, ROUND} div_state_t;

  typedef enum logic [1:0] {SPEC_NONE, SPEC_NAN, SPEC_INF, SPEC_ZERO} spec_t;

endpackage

// File: rtl/bf16_round_pack.sv
// Round-to-nearest-even on a normalised significand, then overflow/flush and pack.
module bf16_round_pack
  import bf16_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [7:0]        sig,
  input  logic              guard,
  input  logic              sticky,
  output logic [15:0]       result_c
);

  logic              inc;
  logic [8:0]        sig_inc;
  logic signed [9:0] exp_rnd;
  logic              unused_hidden;
  bf16_t             res;

  // A carry out of the significand leaves the low 7 bits at zero, i.e. sig=8'h80.
  always_comb begin
    inc           = guard & (sticky | sig[0]);
    sig_inc       = {1'b0, sig} + 9'(inc);
    exp_rnd       = exp_in + 10'(sig_inc[8]);
    unused_hidden = sig_inc[7];
    res           = '{sign: sign, exp: exp_rnd[7:0], frac: sig_inc[6:0]};
    if (exp_rnd >= 10'sd255) begin
      res = '{sign: sign, exp: BF16_EXP_MAX, frac: 7'h00};
    end else if (exp_rnd <= 10'sd0) begin
      res = '{sign: sign, exp: 8'h00, frac: 7'h00};
    end
    result_c = res;
  end

endmodule

// File: rtl/div_bf16.sv
// Multi-cycle bfloat16 divider: restoring radix-2, one quotient bit per cycle,
// RNE rounding, subnormals flushed; fixed latency for every operand pair.
module div_bf16
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        done,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REM_W = 9;

  div_state_t                state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [BF16_QUOT_BITS-1:0] q, q_n;
  logic [REM_W-1:0]          rem, rem_n;
  logic [7:0]                mb, mb_n;
  logic signed [9:0]         ediff, ediff_n;
  logic                      sign, sign_n;
  spec_t                     kind, kind_n;
  logic [15:0]               result_n;
  logic                      done_n, busy_n;

  bf16_t op_a, op_b;
  logic  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  spec_t spec_c;

  logic             qbit;
  logic [REM_W-1:0] diff, rem_sel;

  logic              norm_hi;
  logic signed [9:0] e_norm;
  logic [7:0]        sig_norm;
  logic              guard, sticky;
  logic [15:0]       packed_c;

  assign op_a = a;
  assign op_b = b;

  // Operand classification; exponent 0 is zero regardless of fraction.
  always_comb begin
    a_zero = (op_a.exp == 8'h00);
    b_zero = (op_b.exp == 8'h00);
    a_inf  = (op_a.exp == BF16_EXP_MAX) && (op_a.frac == 7'h00);
    b_inf  = (op_b.exp == BF16_EXP_MAX) && (op_b.frac == 7'h00);
    a_nan  = (op_a.exp == BF16_EXP_MAX) && (op_a.frac != 7'h00);
    b_nan  = (op_b.exp == BF16_EXP_MAX) && (op_b.frac != 7'h00);
    if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
      spec_c = SPEC_NAN;
    end else if (a_inf | b_zero) begin
      spec_c = SPEC_INF;
    end else if (a_zero | b_inf) begin
      spec_c = SPEC_ZERO;
    end else begin
      spec_c = SPEC_NONE;
    end
  end

  // Restoring step: the partial remainder already holds the next dividend bit.
  always_comb begin
    qbit    = (rem >= REM_W'(mb));
    diff    = rem - REM_W'(mb);
    rem_sel = qbit ? diff : rem;
  end

  // Normalise: the quotient lies in (0.5, 2), so q[10] or q[9] is the leading one.
  always_comb begin
    norm_hi  = q[BF16_QUOT_BITS-1];
    e_norm   = ediff + (norm_hi ? 10'(BF16_BIAS) : 10'(BF16_BIAS - 1));
    sig_norm = norm_hi ? q[10:3] : q[9:2];
    guard    = norm_hi ? q[2] : q[1];
    sticky   = (norm_hi ? (q[1] | q[0]) : q[0]) | (rem != '0);
  end

  bf16_round_pack u_round_pack (
    .sign     (sign),
    .exp_in   (e_norm),
    .sig      (sig_norm),
    .guard    (guard),
    .sticky   (sticky),
    .result_c (packed_c)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    q_n      = q;
    rem_n    = rem;
    mb_n     = mb;
    ediff_n  = ediff;
    sign_n   = sign;
    kind_n   = kind;
    result_n = result;
    done_n   = 1'b0;
    busy_n   = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          sign_n  = op_a.sign ^ op_b.sign;
          ediff_n = 10'(op_a.exp) - 10'(op_b.exp);
          rem_n   = REM_W'({1'b1, op_a.frac});
          mb_n    = {1'b1, op_b.frac};
          kind_n  = spec_c;
          q_n     = '0;
          cnt_n   = '0;
          state_n = DIV;
        end
      end
      DIV: begin
        q_n   = {q[BF16_QUOT_BITS-2:0], qbit};
        rem_n = REM_W'({rem_sel, 1'b0});
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BF16_QUOT_BITS - 1)) begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        done_n  = 1'b1;
        state_n = IDLE;
        case (kind)
          SPEC_NAN:  result_n = BF16_QNAN;
          SPEC_INF:  result_n = {sign, BF16_EXP_MAX, 7'h00};
          SPEC_ZERO: result_n = {sign, 15'h0000};
          default:   result_n = packed_c;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cnt    <= '0;
      q      <= '0;
      rem    <= '0;
      mb     <= '0;
      ediff  <= '0;
      sign   <= 1'b0;
      kind   <= SPEC_NONE;
      result <= 16'h0000;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      q      <= q_n;
      rem    <= rem_n;
      mb     <= mb_n;
      ediff  <= ediff_n;
      sign   <= sign_n;
      kind   <= kind_n;
      result <= result_n;
      done   <= done_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_div_bf16.sv
// Bench for div_bf16: vector table plus handshake/reset sequences, checked
// through a scoreboard of expected results and completion cycles.
module tb_div_bf16;

  logic        clk, nRST, start;
  logic [15:0] a, b, result;
  logic        done, busy;

  div_bf16 dut (
    .clk    (clk),
    .nRST   (nRST),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          due;
  } sb_t;

  localparam int NV = 18;

  vec_t        vecs[NV];
  sb_t         sbq[$];
  int          total, bad, cyc, acc_edge, done_seen, d0;
  bit          active;
  logic [15:0] exp_cur, last_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d", nm, act, want, cyc);
    end
  endtask

  // Posedge: model acceptance and queue the expected result; negedge: compare.
  task automatic scoreboard();
    sb_t e;
    int  k;
    bit  exp_busy;
    forever begin
      @(clk or negedge nRST);
      if (!nRST) begin
        sbq.delete();
        active   = 0;
        last_exp = 16'h0000;
      end else if (clk) begin
        cyc++;
        if (active && cyc == acc_edge + 13) active = 0;
        if (!active && start) begin
          sbq.push_back('{exp_cur, cyc + 12});
          active   = 1;
          acc_edge = cyc;
        end
      end else begin
        k        = cyc - acc_edge;
        exp_busy = active && k >= 1 && k <= 12;
        check("busy", int'(busy), int'(exp_busy));
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          e = sbq.pop_front();
          check("done", int'(done), 1);
          check("result", int'(result), int'(e.res));
          last_exp = e.res;
        end else begin
          check("done_idle", int'(done), 0);
          check("result_hold", int'(result), int'(last_exp));
        end
        if (done) done_seen++;
      end
    end
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; a = '0; b = '0; exp_cur = '0; last_exp = '0;
    total = 0; bad = 0; cyc = 0; acc_edge = 0; done_seen = 0; active = 0;

    vecs[0]  = '{16'h3F80, 16'h3F80, 16'h3F80};
    vecs[1]  = '{16'h40C0, 16'h4000, 16'h4040};
    vecs[2]  = '{16'h3F80, 16'h4040, 16'h3EAB};
    vecs[3]  = '{16'hBF80, 16'h0000, 16'hFF80};
    vecs[4]  = '{16'h0000, 16'h0000, 16'h7FC0};
    vecs[5]  = '{16'h7FC1, 16'h3F80, 16'h7FC0};
    vecs[6]  = '{16'h8000, 16'h4000, 16'h8000};
    vecs[7]  = '{16'h3F80, 16'h7F80, 16'h0000};
    vecs[8]  = '{16'h7F00, 16'h0080, 16'h7F80};
    vecs[9]  = '{16'h0080, 16'h7F00, 16'h0000};
    vecs[10] = '{16'h0040, 16'h3F80, 16'h0000};
    vecs[11] = '{16'h4040, 16'h4000, 16'h3FC0};
    vecs[12] = '{16'h7F80, 16'h3F80, 16'h7F80};
    vecs[13] = '{16'h7F80, 16'hFF80, 16'h7FC0};
    vecs[14] = '{16'hC000, 16'h3F80, 16'hC000};
    vecs[15] = '{16'h4000, 16'h4040, 16'h3F2B};
    vecs[16] = '{16'h3F80, 16'hC040, 16'hBEAB};
    vecs[17] = '{16'h40E0, 16'h4040, 16'h4015};

    fork
      scoreboard();
    join_none

    repeat (3) @(negedge clk);
    check("rst_result", int'(result), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    nRST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      a = vecs[i].a; b = vecs[i].b; exp_cur = vecs[i].q; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
    end

    // start held for 20 cycles; operands change mid-flight and must not disturb it
    d0 = done_seen;
    a = 16'h4040; b = 16'h4000; exp_cur = 16'h3FC0; start = 1'b1;
    repeat (5) @(negedge clk);
    a = 16'h3F80; b = 16'h3F80; exp_cur = 16'h3F80;
    repeat (15) @(negedge clk);
    start = 1'b0;
    check("held_start_dones", done_seen - d0, 1);
    repeat (14) @(negedge clk);
    check("held_start_total", done_seen - d0, 2);

    // back-to-back: start in the done cycle is accepted
    a = 16'h3F80; b = 16'h3F80; exp_cur = 16'h3F80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("done_cycle", int'(done), 1);
    a = 16'h40C0; b = 16'h4000; exp_cur = 16'h4040; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);

    // asynchronous reset during DIV
    a = 16'h3F80; b = 16'h4040; exp_cur = 16'h3EAB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    check("midrst_result", int'(result), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    nRST = 1'b1;
    a = 16'h4000; b = 16'h4040; exp_cur = 16'h3F2B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
